// File: rtl/dir_ctrl_pkg.sv
// rtl/dir_ctrl_pkg.sv - direction and game-state encodings shared by the direction controller
package dir_ctrl_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  localparam logic [1:0] GS_NORMAL = 2'b00;
  localparam logic [1:0] GS_APPLE  = 2'b01;
  localparam logic [1:0] GS_DEAD   = 2'b10;

  // Priority up > down > left > right; right is the fall-through, so its bit is not needed.
  function automatic logic [1:0] pick_dir(input logic [2:0] up_down_left);
    if (up_down_left[2])      return DIR_UP;
    else if (up_down_left[1]) return DIR_DOWN;
    else if (up_down_left[0]) return DIR_LEFT;
    else                      return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/dir_ctrl_btn_debounce.sv
// rtl/dir_ctrl_btn_debounce.sv - two-flop synchroniser, stability counter and press pulse
module btn_debounce #(
  parameter int DB_LIMIT = 50000,
  parameter int DB_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam logic [DB_W-1:0] LAST = DB_W'(DB_LIMIT - 1);

  logic            sync1;
  logic            sync2;
  logic            level;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Level flips after DB_LIMIT consecutive disagreeing samples; pulse only on release->press.
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/dir_ctrl.sv
// rtl/dir_ctrl.sv - debounced buttons to a two-deep turn queue committed on move_clk rises
module dir_ctrl
  import dir_ctrl_pkg::*;
#(
  parameter int         DB_LIMIT = 50000,
  parameter int         DB_W     = 16,
  parameter logic [1:0] INIT_DIR = DIR_RIGHT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       move_clk,
  input  logic       start,
  input  logic [1:0] game_state,
  output logic [1:0] sw,
  output logic [1:0] q_count,
  output logic       turn_accepted,
  output logic       turn_dropped
);

  logic [3:0] press;

  btn_debounce #(.DB_LIMIT(DB_LIMIT), .DB_W(DB_W)) u_db_up (
    .clk(clk), .rst(rst), .raw(btn_up), .press(press[3]));
  btn_debounce #(.DB_LIMIT(DB_LIMIT), .DB_W(DB_W)) u_db_down (
    .clk(clk), .rst(rst), .raw(btn_down), .press(press[2]));
  btn_debounce #(.DB_LIMIT(DB_LIMIT), .DB_W(DB_W)) u_db_left (
    .clk(clk), .rst(rst), .raw(btn_left), .press(press[1]));
  btn_debounce #(.DB_LIMIT(DB_LIMIT), .DB_W(DB_W)) u_db_right (
    .clk(clk), .rst(rst), .raw(btn_right), .press(press[0]));

  logic       mc_d1;
  logic       mc_d2;
  logic [1:0] q0;
  logic [1:0] q1;

  logic       dead;
  logic       pop;
  logic       req_valid;
  logic [1:0] req;
  logic [1:0] ref_dir;
  logic       axis_ok;
  logic       room;
  logic       push;
  logic       drop;
  logic [1:0] base;
  logic [1:0] n_sw;
  logic [1:0] n_q0;
  logic [1:0] n_q1;
  logic [1:0] n_cnt;

  always_comb begin
    dead      = (game_state == GS_DEAD);
    pop       = mc_d1 & ~mc_d2 & start & (q_count != 2'd0) & ~dead;
    req_valid = (|press) & ~dead;
    req       = pick_dir(press[3:1]);
    // Turns are judged against the newest pending turn, so chained taps build a path.
    ref_dir   = (q_count == 2'd2) ? q1 : (q_count == 2'd1) ? q0 : sw;
    axis_ok   = (req[1] != ref_dir[1]);
    room      = (q_count != 2'd2) | pop;
    push      = req_valid & axis_ok & room;
    drop      = req_valid & ~(axis_ok & room);

    n_sw  = sw;
    n_q0  = q0;
    n_q1  = q1;
    n_cnt = q_count;
    base  = q_count;
    if (dead) begin
      n_cnt = 2'd0;
    end else begin
      if (pop) begin
        n_sw  = q0;
        n_q0  = q1;
        base  = q_count - 2'd1;
        n_cnt = base;
      end
      if (push) begin
        if (base == 2'd0) n_q0 = req;
        else              n_q1 = req;
        n_cnt = base + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_d1         <= 1'b0;
      mc_d2         <= 1'b0;
      sw            <= INIT_DIR;
      q0            <= DIR_RIGHT;
      q1            <= DIR_RIGHT;
      q_count       <= 2'd0;
      turn_accepted <= 1'b0;
      turn_dropped  <= 1'b0;
    end else begin
      mc_d1         <= move_clk;
      mc_d2         <= mc_d1;
      sw            <= n_sw;
      q0            <= n_q0;
      q1            <= n_q1;
      q_count       <= n_cnt;
      turn_accepted <= push;
      turn_dropped  <= drop;
    end
  end

endmodule

// File: tb/tb_dir_ctrl.sv
// tb/tb_dir_ctrl.sv - vector table, timed corner sequences and randomized run against a queue model
module tb_dir_ctrl;

  localparam int DBL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0;
  logic       move_clk = 1'b0;
  logic       start = 1'b0;
  logic [1:0] game_state = 2'b00;
  logic [1:0] sw;
  logic [1:0] q_count;
  logic       turn_accepted;
  logic       turn_dropped;

  dir_ctrl #(.DB_LIMIT(DBL), .DB_W(3), .INIT_DIR(2'b00)) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn[3]), .btn_down(btn[2]), .btn_left(btn[1]), .btn_right(btn[0]),
    .move_clk(move_clk), .start(start), .game_state(game_state),
    .sw(sw), .q_count(q_count), .turn_accepted(turn_accepted), .turn_dropped(turn_dropped));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;
  int drp_cnt = 0;
  bit chk_en  = 0;

  // Reference model: press = DB_LIMIT consecutive synchronised samples differing from the level.
  logic [1:0] mq[$];
  logic [1:0] m_sw;
  bit         m_acc, m_drp;
  bit         m_lvl[4];
  bit         m_prs[4];
  bit         hist[4][0:DBL+1];
  bit         mh[2];
  bit         m_dead, m_pop, m_reqv, m_diff;
  logic [1:0] m_req, m_ref;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_sw = 2'b00; m_acc = 0; m_drp = 0; mh[0] = 0; mh[1] = 0;
      for (int b = 0; b < 4; b++) begin
        m_lvl[b] = 0; m_prs[b] = 0;
        for (int i = 0; i < DBL + 2; i++) hist[b][i] = 0;
      end
    end else begin
      m_dead = (game_state == 2'b10);
      m_pop  = mh[0] && !mh[1] && start && mq.size() > 0 && !m_dead;
      m_reqv = 0; m_req = 2'b00;
      if (m_prs[0]) begin m_reqv = 1; m_req = 2'b00; end
      if (m_prs[1]) begin m_reqv = 1; m_req = 2'b01; end
      if (m_prs[2]) begin m_reqv = 1; m_req = 2'b10; end
      if (m_prs[3]) begin m_reqv = 1; m_req = 2'b11; end
      m_ref = (mq.size() > 0) ? mq[mq.size()-1] : m_sw;
      m_acc = 0; m_drp = 0;
      if (m_dead) mq.delete();
      else begin
        if (m_pop) m_sw = mq.pop_front();
        if (m_reqv) begin
          if (m_req[1] == m_ref[1]) m_drp = 1;
          else if (mq.size() < 2) begin mq.push_back(m_req); m_acc = 1; end
          else m_drp = 1;
        end
      end
      for (int b = 0; b < 4; b++) begin
        m_diff = 1;
        for (int i = 1; i <= DBL; i++) if (hist[b][i] == m_lvl[b]) m_diff = 0;
        m_prs[b] = 0;
        if (m_diff) begin m_lvl[b] = !m_lvl[b]; m_prs[b] = m_lvl[b]; end
        for (int i = DBL + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = btn[b];
      end
      mh[1] = mh[0]; mh[0] = move_clk;
    end
  end

  int qs;
  always @(negedge clk) begin
    if (chk_en) begin
      qs = mq.size();
      n_tests++;
      if (sw !== m_sw || q_count !== qs[1:0] || turn_accepted !== m_acc || turn_dropped !== m_drp) begin
        n_fail++;
        $display("FAIL model t=%0t sw=%0d q=%0d acc=%0d drp=%0d expected sw=%0d q=%0d acc=%0d drp=%0d",
                 $time, sw, q_count, turn_accepted, turn_dropped, m_sw, qs, m_acc, m_drp);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
    acc_cnt += int'(turn_accepted);
    drp_cnt += int'(turn_dropped);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1; btn = 0; move_clk = 0; game_state = 2'b00;
    repeat (3) cyc();
    rst = 0;
    cyc();
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    repeat (10) cyc();
    btn = 0;
    repeat (4) cyc();
  endtask

  task automatic mc_pulse();
    move_clk = 1;
    repeat (3) cyc();
    move_clk = 0;
    repeat (3) cyc();
  endtask

  typedef struct {
    logic [3:0] btn;
    int         hold;
    bit         mc;
    bit         st;
    logic [1:0] gs;
    logic [1:0] e_sw;
    logic [1:0] e_q;
    int         e_acc;
    int         e_drp;
  } vec_t;

  vec_t vecs[15];
  int   k;
  bit   got;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    do_reset();
    chk_en = 1;
    start = 1; acc_cnt = 0; drp_cnt = 0;
    repeat (50) cyc();
    check("idle_sw", 32'(sw), 0);
    check("idle_q", 32'(q_count), 0);
    check("idle_acc", acc_cnt, 0);
    check("idle_drp", drp_cnt, 0);

    //          btn     hold mc st gs     sw     q   acc drp
    vecs[0]  = '{4'b1000, 3,  0, 1, 2'b00, 2'b00, 2'd0, 0, 0};
    vecs[1]  = '{4'b1000, 10, 1, 1, 2'b00, 2'b11, 2'd0, 1, 0};
    vecs[2]  = '{4'b0001, 10, 1, 1, 2'b00, 2'b00, 2'd0, 1, 0};
    vecs[3]  = '{4'b0010, 10, 0, 1, 2'b00, 2'b00, 2'd0, 0, 1};
    vecs[4]  = '{4'b1000, 10, 0, 1, 2'b00, 2'b00, 2'd1, 1, 0};
    vecs[5]  = '{4'b0001, 10, 0, 1, 2'b00, 2'b00, 2'd2, 1, 0};
    vecs[6]  = '{4'b0100, 10, 0, 1, 2'b00, 2'b00, 2'd2, 0, 1};
    vecs[7]  = '{4'b0010, 10, 0, 1, 2'b00, 2'b00, 2'd2, 0, 1};
    vecs[8]  = '{4'b0000, 0,  1, 0, 2'b00, 2'b00, 2'd2, 0, 0};
    vecs[9]  = '{4'b0000, 0,  1, 1, 2'b00, 2'b11, 2'd1, 0, 0};
    vecs[10] = '{4'b0010, 10, 1, 1, 2'b10, 2'b11, 2'd0, 0, 0};
    vecs[11] = '{4'b0010, 10, 1, 1, 2'b00, 2'b01, 2'd0, 1, 0};
    vecs[12] = '{4'b1010, 10, 1, 1, 2'b00, 2'b11, 2'd0, 1, 0};
    vecs[13] = '{4'b0101, 10, 0, 1, 2'b00, 2'b11, 2'd0, 0, 1};
    vecs[14] = '{4'b0001, 10, 1, 1, 2'b01, 2'b00, 2'd0, 1, 0};

    for (int i = 0; i < 15; i++) begin
      acc_cnt = 0; drp_cnt = 0;
      start = vecs[i].st; game_state = vecs[i].gs;
      if (vecs[i].btn != 0) begin
        btn = vecs[i].btn;
        repeat (vecs[i].hold) cyc();
        btn = 0;
        repeat (10) cyc();
      end
      if (vecs[i].mc) begin
        move_clk = 1; repeat (3) cyc(); move_clk = 0; repeat (4) cyc();
      end else repeat (2) cyc();
      check($sformatf("vec%0d_sw", i), 32'(sw), 32'(vecs[i].e_sw));
      check($sformatf("vec%0d_q", i), 32'(q_count), 32'(vecs[i].e_q));
      check($sformatf("vec%0d_acc", i), acc_cnt, vecs[i].e_acc);
      check($sformatf("vec%0d_drp", i), drp_cnt, vecs[i].e_drp);
      game_state = 2'b00;
    end

    // Press latency and commit latency
    do_reset();
    start = 1; acc_cnt = 0;
    btn = 4'b1000; k = 0; got = 0;
    while (k < 40 && !got) begin
      cyc(); k++;
      if (turn_accepted) got = 1;
    end
    btn = 0;
    check("press_to_accept_cycles", k, 7);
    check("commit_q_before", 32'(q_count), 1);
    repeat (3) cyc();
    move_clk = 1;
    cyc();
    check("commit_sw_after1", 32'(sw), 0);
    cyc();
    check("commit_sw_after2", 32'(sw), 3);
    check("commit_q_after2", 32'(q_count), 0);
    check("commit_acc_once", acc_cnt, 1);
    move_clk = 0;
    repeat (3) cyc();

    // Simultaneous pop and push on a full queue
    do_reset();
    start = 1;
    press(4'b1000);
    press(4'b0001);
    check("full_q", 32'(q_count), 2);
    btn = 4'b0100;
    repeat (5) cyc();
    move_clk = 1;
    cyc(); cyc();
    check("simul_sw", 32'(sw), 3);
    check("simul_q", 32'(q_count), 2);
    check("simul_acc", 32'(turn_accepted), 1);
    check("simul_drp", 32'(turn_dropped), 0);
    btn = 0; move_clk = 0;
    repeat (4) cyc();
    mc_pulse();
    check("simul_pop1", 32'(sw), 0);
    mc_pulse();
    check("simul_pop2", 32'(sw), 2);
    check("simul_empty", 32'(q_count), 0);

    // Dead flush
    press(4'b0010);
    press(4'b1000);
    check("dead_pre_q", 32'(q_count), 2);
    game_state = 2'b10;
    cyc();
    check("dead_flush_q", 32'(q_count), 0);
    btn = 4'b0001;
    repeat (10) cyc();
    btn = 0;
    mc_pulse();
    mc_pulse();
    check("dead_sw_hold", 32'(sw), 2);
    check("dead_q_hold", 32'(q_count), 0);
    game_state = 2'b00;
    repeat (3) cyc();

    // Randomized run against the model
    for (int it = 0; it < 1500; it++) begin
      btn        = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'b0;
      move_clk   = 1'($urandom());
      start      = ($urandom_range(0, 7) != 0);
      game_state = ($urandom_range(0, 30) == 0) ? 2'b10 :
                   ($urandom_range(0, 5) == 0)  ? 2'b01 : 2'b00;
      if ($urandom_range(0, 200) == 0) begin
        rst = 1; cyc(); cyc(); rst = 0;
      end
      repeat ($urandom_range(1, 12)) cyc();
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
